// File: rtl/ifq_line_fetch.sv
// Instruction fetch queue: requests whole cache lines, pushes all useful
// instructions of a returned line at once, bypasses to dispatch when empty.
module ifq_line_fetch #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       INST_W     = 32,
  parameter int unsigned       LINE_INSTS = 4,
  parameter int unsigned       DEPTH      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDR_W-1:0]            pc_in,
  output logic                         cache_rd_en,
  output logic                         cache_abort,
  input  logic [LINE_INSTS*INST_W-1:0] dout,
  input  logic                         dout_valid,
  output logic [ADDR_W-1:0]            pc_out,
  output logic [INST_W-1:0]            inst,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH):0]       count,
  input  logic                         inst_rd_en,
  input  logic [ADDR_W-1:0]            jmp_branch_address,
  input  logic                         jmp_branch_valid
);

  localparam int unsigned IDX_W = $clog2(LINE_INSTS);
  localparam int unsigned OFS   = IDX_W + 2;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [ADDR_W-1:0]  mem_pc_q   [DEPTH];
  logic [INST_W-1:0]  mem_inst_q [DEPTH];

  logic [INST_W-1:0]  line_w    [LINE_INSTS];
  logic [INST_W-1:0]  slot_inst [LINE_INSTS];
  logic [ADDR_W-1:0]  slot_pc   [LINE_INSTS];
  logic [IDX_W:0]     src;

  logic [IDX_W-1:0]   off;
  logic [ADDR_W-1:0]  line_base;
  logic [CNT_W-1:0]   k;
  logic [CNT_W-1:0]   space;
  logic [CNT_W-1:0]   npush;
  logic               space_ok;
  logic               stored;
  logic               in_wait;
  logic               line_ok;
  logic               bypass;
  logic               pop;
  logic               byp_pop;
  logic               st_pop;
  logic               addr_unused;

  assign addr_unused = ^jmp_branch_address[1:0];

  assign off       = fetch_pc_q[OFS-1:2];
  assign line_base = {fetch_pc_q[ADDR_W-1:OFS], {OFS{1'b0}}};
  assign k         = CNT_W'(LINE_INSTS) - CNT_W'(off);
  assign space     = CNT_W'(DEPTH) - count_q;
  assign space_ok  = (space >= k);
  assign stored    = (count_q != '0);
  assign in_wait   = (state_q == S_WAIT);

  // A line arriving together with a redirect is dropped.
  assign line_ok   = in_wait & dout_valid & ~jmp_branch_valid;
  assign bypass    = line_ok & ~stored;

  assign empty     = ~(stored | bypass);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign pc_in     = line_base;

  assign pop       = inst_rd_en & ~empty & ~jmp_branch_valid;
  assign byp_pop   = pop & ~stored;
  assign st_pop    = pop & stored;
  assign npush     = line_ok ? (k - CNT_W'(byp_pop)) : '0;

  // Gated by rst so no request is seen while reset is held.
  assign cache_rd_en = rst & (state_q == S_REQ) & ~jmp_branch_valid & space_ok;
  assign cache_abort = in_wait & jmp_branch_valid & ~dout_valid;

  always_comb begin
    for (int i = 0; i < LINE_INSTS; i++) begin
      line_w[i] = dout[i*INST_W +: INST_W];
    end
  end

  // Head comes from storage, else from the arriving line, else zero.
  always_comb begin
    inst   = '0;
    pc_out = '0;
    if (stored) begin
      inst   = mem_inst_q[rptr_q];
      pc_out = mem_pc_q[rptr_q];
    end else if (bypass) begin
      inst   = line_w[off];
      pc_out = fetch_pc_q;
    end
  end

  // Write slot i takes line word off + (bypass consumed) + i.
  always_comb begin
    src = '0;
    for (int i = 0; i < LINE_INSTS; i++) begin
      src          = (IDX_W+1)'(off) + (IDX_W+1)'(byp_pop) + (IDX_W+1)'(i);
      slot_inst[i] = line_w[src[IDX_W-1:0]];
      slot_pc[i]   = line_base + (ADDR_W'(src) << 2);
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    if (jmp_branch_valid) begin
      state_d    = S_REQ;
      fetch_pc_d = {jmp_branch_address[ADDR_W-1:2], 2'b00};
      rptr_d     = wptr_q;
      count_d    = '0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (space_ok) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (dout_valid) begin
            state_d    = S_REQ;
            fetch_pc_d = line_base + ADDR_W'(LINE_INSTS * 4);
          end
        end
        default: state_d = S_REQ;
      endcase
      wptr_d  = wptr_q + PTR_W'(npush);
      rptr_d  = rptr_q + PTR_W'(st_pop);
      count_d = count_q + npush - CNT_W'(st_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset; reads are masked by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LINE_INSTS; i++) begin
      if (CNT_W'(i) < npush) begin
        mem_inst_q[wptr_q + PTR_W'(i)] <= slot_inst[i];
        mem_pc_q[wptr_q + PTR_W'(i)]   <= slot_pc[i];
      end
    end
  end

endmodule

// File: doc/ifq_line_fetch.md
# ifq_line_fetch

Parametrised instruction fetch queue that sits between the instruction cache and dispatch. It requests whole cache lines and pushes every useful instruction of a returned line in one cycle, honouring the entry offset after a branch. It tracks a byte-addressed PC per entry, bypasses to dispatch when empty, and aborts in-flight cache requests on redirect. Depth, line width and reset vector are parameters.

## Interface
- ADDR_W, 32: address/PC width (byte address).
- INST_W, 32: instruction width.
- LINE_INSTS, 4: instructions per cache line; power of 2, >=2.
- DEPTH, 16: queue entries; power of 2, >= LINE_INSTS.
- RESET_PC, 0: fetch PC after reset; must be 4-byte aligned.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_in  out  ADDR_W  line-aligned fetch address to the cache.
- cache_rd_en  out  1  one-cycle cache request pulse.
- cache_abort  out  1  one-cycle pulse that cancels the outstanding request.
- dout  in  LINE_INSTS*INST_W  returned line; instruction i at bits [i*INST_W +: INST_W].
- dout_valid  in  1  line valid; exactly once per non-aborted request.
- pc_out  out  ADDR_W  byte PC of the head instruction.
- inst  out  INST_W  head instruction.
- empty  out  1  no head instruction available, bypass included.
- full  out  1  count == DEPTH.
- count  out  $clog2(DEPTH)+1  stored entries, bypass excluded.
- inst_rd_en  in  1  dispatch pops the head.
- jmp_branch_address  in  ADDR_W  redirect target.
- jmp_branch_valid  in  1  redirect strobe.

## Operation
- OFS = $clog2(LINE_INSTS)+2. fetch_pc holds the byte PC. off = fetch_pc[OFS-1:2]. k = LINE_INSTS - off is the number of useful instructions in the line. pc_in = {fetch_pc[ADDR_W-1:OFS], OFS'b0}.
- Each entry stores {pc, inst}. Read and write pointers wrap modulo DEPTH.
- The FSM has two states, REQ and WAIT.
  - REQ: cache_rd_en = 1 iff (DEPTH - count) >= k, then go to WAIT. Otherwise stay in REQ with cache_rd_en = 0.
  - WAIT: on dout_valid, push instructions off..LINE_INSTS-1. Instruction j gets pc = line_base + 4*j. Then fetch_pc <- line_base + LINE_INSTS*4, off becomes 0, and the FSM returns to REQ.
- Space checked at request time is guaranteed at push time, because pops only add space.
- Bypass: when count == 0 and dout_valid is in WAIT:
  - inst and pc_out show instruction off and its PC combinationally, and empty = 0.
  - If inst_rd_en is high, that instruction is consumed and not stored; only the remaining k-1 are pushed.
- Pop: inst_rd_en with empty = 1 is ignored. Simultaneous push and pop give count' = count + pushed - popped.
- Redirect (jmp_branch_valid) has highest priority in any state:
  - Flush the queue (count' = 0) and ignore inst_rd_en.
  - fetch_pc <- {jmp_branch_address[ADDR_W-1:2], 2'b00}. Next state is REQ.
  - If in WAIT with dout_valid = 0: cache_abort = 1 this cycle. The cache then never returns that line.
  - If in WAIT with dout_valid = 1: the line is discarded and there is no abort.
  - In REQ: no request is issued this cycle.
- inst and pc_out are 0 when empty = 1.
- fetch_pc wraps at 2^ADDR_W.

## Timing
- Reset (rst low, asynchronous) sets:
  - state = REQ, fetch_pc = RESET_PC, pointers and count = 0.
  - cache_rd_en = 0, cache_abort = 0, empty = 1, full = 0, inst = 0, pc_out = 0.
- First request occurs in the first cycle after rst deasserts.
- Reset mid-request drops the request; the cache must ignore dout_valid after reset.
- Latency:
  - Bypass instruction: visible in the dout_valid cycle.
  - Stored instructions: visible from the next cycle.
  - Next request: earliest the cycle after dout_valid (REQ).
- cache_abort and cache_rd_en are never high in the same cycle.
- count, full and empty (non-bypass) are registered-state derived.

## Test plan
- Reset with RESET_PC=0x100, LINE_INSTS=4, DEPTH=16, 1-cycle cache, no pops -> pc_in=0x100 with rd_en pulses; count reaches 4, 8, 12, 16; full=1; rd_en stays 0 afterwards.
- Empty queue, line returned with inst_rd_en=1 -> inst = word0 and pc_out = 0x100 in the dout_valid cycle; the next cycle gives count=3 and pc_out=0x104.
- Branch to 0x208 while idle -> pc_in=0x200; only words 2 and 3 are pushed with PCs 0x208 and 0x20C; next pc_in=0x210.
- Branch in WAIT with dout_valid=0 -> cache_abort for 1 cycle, count=0, next request to the target line. Branch in the same cycle as dout_valid -> line discarded, no abort.
- count=13 with off=0 -> no request. Pop one -> request issues the next cycle. Simultaneous pop and 4-push -> count+3. Pointer wrap past entry 15 preserves FIFO order.
